// File: rtl/reset_sequencer_pkg.sv
// Shared types and elaboration-time helpers for reset_sequencer.
// Build option: define RESET_SEQUENCER_CAUSE_EN to include the sticky reset-cause flags.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } seq_state_t;

  // The counter never holds more than the larger of the two reload values.
  function automatic int cnt_width(input int min_assert, input int stage_gap);
    int max_load;
    max_load = (min_assert > stage_gap) ? min_assert : stage_gap;
    return $clog2(max_load + 1);
  endfunction

  function automatic bit params_ok(input int n_req, input int n_domains, input int sync_depth,
                                   input int min_assert, input int stage_gap);
    return (n_req >= 1) && (n_domains >= 1) && (sync_depth >= 2) &&
           (min_assert >= 1) && (stage_gap >= 1);
  endfunction

endpackage

// File: rtl/reset_request_sync.sv
// One SYNC_DEPTH-deep synchroniser for a single asynchronous reset request.
// Output is normalised to active-high regardless of REQ_ACTIVE_STATE.
module reset_request_sync #(
  parameter int   SYNC_DEPTH       = 2,
  parameter logic REQ_ACTIVE_STATE = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_req,
  output logic o_req_sync
);

  (* ASYNC_REG = "TRUE", preserve, dont_touch = "true", IOB = "FALSE", useioff = 0 *)
  logic [SYNC_DEPTH-1:0] r_sync;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_sync <= {SYNC_DEPTH{~REQ_ACTIVE_STATE}};
    end else begin
      r_sync <= {r_sync[SYNC_DEPTH-2:0], i_req};
    end
  end

  assign o_req_sync = (r_sync[SYNC_DEPTH-1] == REQ_ACTIVE_STATE);

endmodule

// File: rtl/reset_sequencer.sv
// Multi-source reset controller: synchronises requests, holds all resets, then releases domains in order.
// Build option: RESET_SEQUENCER_CAUSE_EN adds sticky reset_cause flags; otherwise reset_cause is 0.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int   N_REQ              = 2,
  parameter logic REQ_ACTIVE_STATE   = 1'b1,
  parameter int   N_DOMAINS          = 3,
  parameter logic RESET_ACTIVE_STATE = 1'b0,
  parameter int   SYNC_DEPTH         = 2,
  parameter int   MIN_ASSERT         = 4,
  parameter int   STAGE_GAP          = 3
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [N_REQ-1:0]     reset_req,
  input  logic                 sw_reset,
  output logic [N_DOMAINS-1:0] reset_out,
  output logic                 busy,
  output logic                 sequence_done,
  output logic [N_REQ:0]       reset_cause,
  input  logic                 cause_clear
);

  localparam int CNT_W = cnt_width(MIN_ASSERT, STAGE_GAP);
  localparam int IDX_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

  localparam logic [CNT_W-1:0]     CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]     CNT_ASSERT = CNT_W'(MIN_ASSERT);
  localparam logic [CNT_W-1:0]     CNT_GAP    = CNT_W'(STAGE_GAP);
  localparam logic [IDX_W-1:0]     IDX_LAST   = IDX_W'(N_DOMAINS - 1);
  localparam logic [N_DOMAINS-1:0] ALL_ACTIVE = {N_DOMAINS{RESET_ACTIVE_STATE}};

  generate
    if (!params_ok(N_REQ, N_DOMAINS, SYNC_DEPTH, MIN_ASSERT, STAGE_GAP)) begin : g_bad_params
      $error("reset_sequencer: need N_REQ>=1, N_DOMAINS>=1, SYNC_DEPTH>=2, MIN_ASSERT>=1, STAGE_GAP>=1");
    end
  endgenerate

  logic [N_REQ-1:0] w_req_sync;
  logic             w_req_any;
  logic             r_sw_reset;

  for (genvar g = 0; g < N_REQ; g++) begin : g_sync
    reset_request_sync #(
      .SYNC_DEPTH       (SYNC_DEPTH),
      .REQ_ACTIVE_STATE (REQ_ACTIVE_STATE)
    ) u_sync (
      .clock      (clock),
      .reset_n    (reset_n),
      .i_req      (reset_req[g]),
      .o_req_sync (w_req_sync[g])
    );
  end

  // sw_reset is already synchronous; one register aligns it with the FSM's registered view of requests.
  always_ff @(posedge clock) begin
    if (!reset_n) r_sw_reset <= 1'b0;
    else          r_sw_reset <= sw_reset;
  end

  assign w_req_any = (|w_req_sync) | r_sw_reset;

  seq_state_t           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [N_DOMAINS-1:0] r_reset_out;
  logic                 r_busy;
  logic                 r_done;

  // A request outranks any release due on the same edge, including mid-RELEASE.
  always_ff @(posedge clock) begin
    if (!reset_n || w_req_any) begin
      r_state     <= ASSERT;
      r_cnt       <= CNT_ASSERT;
      r_idx       <= '0;
      r_reset_out <= ALL_ACTIVE;
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        ASSERT: begin
          if (r_cnt == CNT_ONE) begin
            r_reset_out[0] <= ~RESET_ACTIVE_STATE;
            if (N_DOMAINS == 1) begin
              r_state <= RUN;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= RELEASE;
              r_cnt   <= CNT_GAP;
              r_idx   <= IDX_W'(1);
            end
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        RELEASE: begin
          if (r_cnt == CNT_ONE) begin
            r_reset_out[r_idx] <= ~RESET_ACTIVE_STATE;
            if (r_idx == IDX_LAST) begin
              r_state <= RUN;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
              r_cnt <= CNT_GAP;
            end
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign reset_out     = r_reset_out;
  assign busy          = r_busy;
  assign sequence_done = r_done;

`ifdef RESET_SEQUENCER_CAUSE_EN
  logic [N_REQ:0] r_cause;

  // New cause bits are OR-ed in after the clear, so a same-edge request survives cause_clear.
  always_ff @(posedge clock) begin
    if (!reset_n) r_cause <= '0;
    else          r_cause <= (cause_clear ? '0 : r_cause) | {r_sw_reset, w_req_sync};
  end

  assign reset_cause = r_cause;
`else
  logic w_unused_cause_clear;
  assign w_unused_cause_clear = cause_clear;
  assign reset_cause          = '0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed self-checking bench for reset_sequencer (N_REQ=2, N_DOMAINS=3, SYNC_DEPTH=2, MIN_ASSERT=4, STAGE_GAP=3).
// Cause expectations follow RESET_SEQUENCER_CAUSE_EN when the bench is built with it.
module tb_reset_sequencer;

`ifdef RESET_SEQUENCER_CAUSE_EN
  localparam bit CAUSE_EN = 1'b1;
`else
  localparam bit CAUSE_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset_n;
  logic [1:0] reset_req;
  logic       sw_reset;
  logic [2:0] reset_out;
  logic       busy;
  logic       sequence_done;
  logic [2:0] reset_cause;
  logic       cause_clear;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  reset_sequencer #(
    .N_REQ              (2),
    .REQ_ACTIVE_STATE   (1'b1),
    .N_DOMAINS          (3),
    .RESET_ACTIVE_STATE (1'b0),
    .SYNC_DEPTH         (2),
    .MIN_ASSERT         (4),
    .STAGE_GAP          (3)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .reset_req     (reset_req),
    .sw_reset      (sw_reset),
    .reset_out     (reset_out),
    .busy          (busy),
    .sequence_done (sequence_done),
    .reset_cause   (reset_cause),
    .cause_clear   (cause_clear)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic logic [2:0] cause_exp(input logic [2:0] v);
    return CAUSE_EN ? v : 3'b000;
  endfunction

  initial begin
    reset_n     = 1'b0;
    reset_req   = 2'b00;
    sw_reset    = 1'b0;
    cause_clear = 1'b0;

    // Release sequence, edge 0 is the reset edge.
    tick(1);
    check("rst_out",   32'(reset_out),     32'h0);
    check("rst_busy",  32'(busy),          32'h1);
    check("rst_done",  32'(sequence_done), 32'h0);
    check("rst_cause", 32'(reset_cause),   32'h0);
    reset_n = 1'b1;
    tick(3);  check("seq_e3",  32'(reset_out), 32'h0);
    tick(1);  check("seq_e4",  32'(reset_out), 32'h1);
              check("seq_e4_busy", 32'(busy),  32'h1);
    tick(2);  check("seq_e6",  32'(reset_out), 32'h1);
    tick(1);  check("seq_e7",  32'(reset_out), 32'h3);
    tick(2);  check("seq_e9",  32'(reset_out), 32'h3);
              check("seq_e9_done", 32'(sequence_done), 32'h0);
    tick(1);  check("seq_e10", 32'(reset_out), 32'h7);
              check("seq_e10_done", 32'(sequence_done), 32'h1);
              check("seq_e10_busy", 32'(busy), 32'h0);

    // Request during RUN: reset_req[1] sampled at edge 20.
    tick(9);
    reset_req = 2'b10;
    tick(1);
    reset_req = 2'b00;
    tick(1);  check("run_req_e21", 32'(reset_out), 32'h7);
    tick(1);  check("run_req_e22", 32'(reset_out), 32'h0);
              check("run_req_busy", 32'(busy), 32'h1);
              check("run_req_done", 32'(sequence_done), 32'h0);
              check("run_req_cause", 32'(reset_cause), 32'(cause_exp(3'b010)));
    tick(3);  check("run_req_e25", 32'(reset_out), 32'h0);
    tick(1);  check("run_req_e26", 32'(reset_out), 32'h1);
    tick(3);  check("run_req_e29", 32'(reset_out), 32'h3);
    tick(3);  check("run_req_e32", 32'(reset_out), 32'h7);
              check("run_req_done2", 32'(sequence_done), 32'h1);

    // sw_reset mid-RELEASE; fresh sequence from a new reset edge 0.
    reset_n = 1'b0;
    tick(1);  check("sw_rst_cause", 32'(reset_cause), 32'h0);
    reset_n = 1'b1;
    tick(7);  check("sw_e7", 32'(reset_out), 32'h3);
    sw_reset = 1'b1;
    tick(1);  check("sw_e8", 32'(reset_out), 32'h3);
    sw_reset = 1'b0;
    tick(1);  check("sw_e9", 32'(reset_out), 32'h0);
              check("sw_e9_busy", 32'(busy), 32'h1);
              check("sw_e9_cause", 32'(reset_cause), 32'(cause_exp(3'b100)));
    tick(1);  check("sw_e10", 32'(reset_out), 32'h0);
    tick(2);  check("sw_e12", 32'(reset_out), 32'h0);
    tick(1);  check("sw_e13", 32'(reset_out), 32'h1);

    // reset_n mid-RELEASE.
    reset_n = 1'b0;
    tick(1);  check("midrel_out",   32'(reset_out),     32'h0);
              check("midrel_busy",  32'(busy),          32'h1);
              check("midrel_done",  32'(sequence_done), 32'h0);
              check("midrel_cause", 32'(reset_cause),   32'h0);
    reset_n = 1'b1;

    // Held request: reset_req[0] sampled high at edges 1..15, FSM sees it at 3..17.
    reset_req = 2'b01;
    tick(4);  check("hold_e4",  32'(reset_out), 32'h0);
    tick(11); check("hold_e15", 32'(reset_out), 32'h0);
    reset_req = 2'b00;
    tick(1);  check("hold_e16", 32'(reset_out), 32'h0);
    tick(4);  check("hold_e20", 32'(reset_out), 32'h0);
    tick(1);  check("hold_e21", 32'(reset_out), 32'h1);
              check("hold_cause", 32'(reset_cause), 32'(cause_exp(3'b001)));
    tick(3);  check("hold_e24", 32'(reset_out), 32'h3);
    tick(3);  check("hold_e27", 32'(reset_out), 32'h7);
              check("hold_done", 32'(sequence_done), 32'h1);

    // cause_clear on the same edge the synced reset_req[0] reaches the FSM.
    sw_reset = 1'b1;
    tick(1);
    sw_reset = 1'b0;
    tick(1);  check("clr_pre_out",   32'(reset_out),   32'h0);
              check("clr_pre_cause", 32'(reset_cause), 32'(cause_exp(3'b101)));
    reset_req = 2'b01;
    tick(1);
    reset_req = 2'b00;
    tick(1);
    cause_clear = 1'b1;
    tick(1);
    cause_clear = 1'b0;
    check("clr_same_cause", 32'(reset_cause), 32'(cause_exp(3'b001)));
    check("clr_same_out",   32'(reset_out),   32'h0);
    cause_clear = 1'b1;
    tick(1);
    cause_clear = 1'b0;
    check("clr_only_cause", 32'(reset_cause), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
